mod_div_6b: RTL and testbench

Sequential 6-bit signed restoring divider for the ALU datapath, the counterpart of the 6-bit add/subtract unit. It takes a signed dividend and divisor and produces a truncated quotient and remainder, one quotient bit per clock, using the same shift-subtract step the subtractor performs. It sits beside the add/subtract and logic units, and the ALU selects its result once `DONE` pulses.

---
 rtl/mod_div_6b.sv | 81 ++++++++
 tb/tb_mod_div_6b.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mod_div_6b.sv
// mod_div_6b: sequential 6-bit signed restoring divider, one quotient bit per clock.
module mod_div_6b (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic [5:0] Q,
  output logic [5:0] R,
  output logic       BUSY,
  output logic       DONE,
  output logic       DIV0,
  output logic       OF
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [5:0] d, bm, p;
  logic [6:0] p_sh, t;
  logic sa, sq;
  // d starts as |A| and fills with quotient bits as the dividend shifts out
  always_comb begin
    p_sh = {p, d[5]};
    t = p_sh - {1'b0, bm};
  end
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= 3'd0;
      d <= 6'd0;
      bm <= 6'd0;
      p <= 6'd0;
      sa <= 1'b0;
      sq <= 1'b0;
      Q <= 6'd0;
      R <= 6'd0;
      DONE <= 1'b0;
      DIV0 <= 1'b0;
      OF <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          if (B == 6'd0) begin
            Q <= 6'd0;
            R <= A;
            DIV0 <= 1'b1;
            OF <= 1'b0;
            DONE <= 1'b1;
          end else begin
            d <= A[5] ? -A : A;
            bm <= B[5] ? -B : B;
            sa <= A[5];
            sq <= A[5] ^ B[5];
            p <= 6'd0;
            cnt <= 3'd0;
            state <= CALC;
          end
        end
        CALC: begin
          p <= t[6] ? p_sh[5:0] : t[5:0];
          d <= {d[4:0], ~t[6]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) state <= SIGN;
        end
        SIGN: begin
          Q <= sq ? -d : d;
          R <= sa ? -p : p;
          OF <= (d == 6'd32) && !sq;
          DIV0 <= 1'b0;
          DONE <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_div_6b.sv
// tb_mod_div_6b: directed and random checks of mod_div_6b against an integer-arithmetic model.
module tb_mod_div_6b;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] a = 6'd0, b = 6'd0, q, r;
  logic busy, done, div0, of;
  int errs = 0, checks = 0;
  logic [5:0] pq = 6'd0, pr = 6'd0;
  mod_div_6b dut (.CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .Q(q), .R(r),
                  .BUSY(busy), .DONE(done), .DIV0(div0), .OF(of));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic model(input logic [5:0] x, input logic [5:0] y, output logic [5:0] eq,
                       output logic [5:0] er, output logic ez, output logic eo);
    int ia, ib, iq, ir;
    ia = $signed(x);
    ib = $signed(y);
    ez = ib == 0;
    eo = ia == -32 && ib == -1;
    iq = ez ? 0 : ia / ib;
    ir = ez ? ia : ia % ib;
    eq = iq[5:0];
    er = ir[5:0];
  endtask
  task automatic check_result(input logic [5:0] eq, input logic [5:0] er, input logic ez, input logic eo);
    chk("q", q, eq);
    chk("r", r, er);
    chk("div0", div0, ez);
    chk("of", of, eo);
    pq = eq;
    pr = er;
  endtask
  task automatic do_op(input logic [5:0] x, input logic [5:0] y);
    logic [5:0] eq, er;
    logic ez, eo;
    int n;
    model(x, y, eq, er, ez, eo);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 6'($urandom);
    b = 6'($urandom);
    if (ez) begin
      chk("dz_done", done, 1);
      chk("dz_busy", busy, 0);
    end else begin
      chk("hold_q", q, pq);
      chk("hold_r", r, pr);
      n = 0;
      while (!done && n < 20) begin
        chk("busy_hi", busy, 1);
        @(posedge clk);
        #1;
        n++;
      end
      chk("latency", n, 7);
      chk("busy_end", busy, 0);
    end
    check_result(eq, er, ez, eo);
    @(posedge clk);
    #1;
    chk("pulse", done, 0);
    chk("hold_after", q, pq);
  endtask
  initial begin
    logic [5:0] eq, er;
    logic ez, eo;
    int last, cnt, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0, 0);
    chk("rst_of", of, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(6'd17, 6'd5);
    do_op(-6'sd17, 6'd5);
    do_op(6'd17, -6'sd5);
    do_op(-6'sd17, -6'sd5);
    do_op(6'b100000, 6'd7);
    do_op(6'b100000, 6'b111111);
    do_op(6'd5, 6'd31);
    do_op(-6'sd9, 6'd0);
    do_op(6'd6, 6'd3);
    // START arriving mid-operation with different operands must be dropped
    model(6'd25, 6'd4, eq, er, ez, eo);
    a = 6'd25;
    b = 6'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 6'd30;
    b = 6'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ign_latency", n, 7);
    check_result(eq, er, ez, eo);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("ign_noqueue", done, 0);
    end
    // START held high: one result every 8 cycles
    a = 6'd17;
    b = 6'd5;
    start = 1'b1;
    last = 0;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        chk("held_gap", c - last, 8);
        chk("held_q", q, 3);
        last = c;
        cnt++;
      end
    end
    start = 1'b0;
    chk("held_count", cnt, 5);
    pq = 6'd3;
    pr = 6'd2;
    @(posedge clk);
    #1;
    // reset in the middle of an operation
    a = 6'd20;
    b = 6'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_div0", div0, 0);
    chk("abort_of", of, 0);
    pq = 6'd0;
    pr = 6'd0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      cnt += int'(done);
    end
    chk("abort_nodone", cnt, 0);
    do_op(6'd20, 6'd3);
    repeat (60) do_op(6'($urandom), ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
